// File: rtl/prbs_pkg.sv
// Shared constants and helpers for the PRBS word generator.
package prbs_pkg;

  localparam logic [2:0] MODE_PRBS7  = 3'd0;
  localparam logic [2:0] MODE_PRBS9  = 3'd1;
  localparam logic [2:0] MODE_PRBS15 = 3'd2;
  localparam logic [2:0] MODE_PRBS23 = 3'd3;
  localparam logic [2:0] MODE_PRBS31 = 3'd4;

  localparam logic [4:0] LEN_PRBS7  = 5'd7;
  localparam logic [4:0] LEN_PRBS9  = 5'd9;
  localparam logic [4:0] LEN_PRBS15 = 5'd15;
  localparam logic [4:0] LEN_PRBS23 = 5'd23;
  localparam logic [4:0] LEN_PRBS31 = 5'd31;

  localparam logic [4:0] TAP_PRBS7  = 5'd6;
  localparam logic [4:0] TAP_PRBS9  = 5'd5;
  localparam logic [4:0] TAP_PRBS15 = 5'd14;
  localparam logic [4:0] TAP_PRBS23 = 5'd18;
  localparam logic [4:0] TAP_PRBS31 = 5'd28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

  function automatic logic mode_legal(logic [2:0] m);
    return (m <= MODE_PRBS31);
  endfunction

  // Reserved modes fall back to PRBS9 geometry so the datapath never sees L=0.
  function automatic logic [4:0] mode_len(logic [2:0] m);
    case (m)
      MODE_PRBS7:  return LEN_PRBS7;
      MODE_PRBS9:  return LEN_PRBS9;
      MODE_PRBS15: return LEN_PRBS15;
      MODE_PRBS23: return LEN_PRBS23;
      MODE_PRBS31: return LEN_PRBS31;
      default:     return LEN_PRBS9;
    endcase
  endfunction

  function automatic logic [4:0] mode_tap(logic [2:0] m);
    case (m)
      MODE_PRBS7:  return TAP_PRBS7;
      MODE_PRBS9:  return TAP_PRBS9;
      MODE_PRBS15: return TAP_PRBS15;
      MODE_PRBS23: return TAP_PRBS23;
      MODE_PRBS31: return TAP_PRBS31;
      default:     return TAP_PRBS9;
    endcase
  endfunction

  // Ones in the low L bits of the 31-bit state.
  function automatic logic [30:0] mode_mask(logic [2:0] m);
    return 31'h7FFF_FFFF >> (5'd31 - mode_len(m));
  endfunction

endpackage

// File: rtl/prbs_if.sv
// Control and output stream bundle of the PRBS generator.
interface prbs_if #(
  parameter int unsigned W     = 1,
  parameter int unsigned CNT_W = 32
);
  logic             i_en;
  logic             i_load;
  logic [2:0]       i_mode;
  logic [30:0]      i_seed;
  logic             i_inj;
  logic             i_ready;
  logic [W-1:0]     o_data;
  logic             o_valid;
  logic             o_seed_fix;
  logic [CNT_W-1:0] o_cnt;

  modport master (
    input  i_en, i_load, i_mode, i_seed, i_inj, i_ready,
    output o_data, o_valid, o_seed_fix, o_cnt
  );

  modport slave (
    output i_en, i_load, i_mode, i_seed, i_inj, i_ready,
    input  o_data, o_valid, o_seed_fix, o_cnt
  );
endinterface

// File: rtl/prbs_lfsr_step.sv
// Advances the LFSR by W single steps and collects the W emitted bits.
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic [30:0]  state,
  input  logic [2:0]   mode,
  output logic [30:0]  state_nxt,
  output logic [W-1:0] word
);

  logic [4:0]  len;
  logic [4:0]  tap_pos;
  logic [30:0] mask;
  logic [30:0] s;
  logic        fb;

  // Unrolled chain: bit out is s[0], XNOR feedback enters at s[L-1].
  always_comb begin
    len     = mode_len(mode);
    tap_pos = len - mode_tap(mode);
    mask    = mode_mask(mode);
    s       = state & mask;
    fb      = 1'b0;
    word    = '0;
    for (int i = 0; i < int'(W); i++) begin
      word[i] = s[0];
      fb      = ~(s[0] ^ s[tap_pos]);
      s       = ((s >> 1) & mask) | ({30'd0, fb} << (len - 5'd1));
    end
    state_nxt = s;
  end

endmodule

// File: rtl/prbs_gen.sv
// PRBS word source: W sequence bits per transfer, runtime mode/seed, error injection.
//
// state | meaning
// IDLE  | no word held; loads accepted; i_en generates the first word
// RUN   | word held on o_data until i_ready accepts it
module prbs_gen
  import prbs_pkg::*;
#(
  parameter int unsigned W            = 1,
  parameter logic [2:0]  DEFAULT_MODE = MODE_PRBS9,
  parameter logic [30:0] SEED         = '0,
  parameter int unsigned CNT_W        = 32
) (
  input logic    clk,
  input logic    rst,
  prbs_if.master bus
);

  state_e           state_q, state_d;
  logic [30:0]      lfsr_q;
  logic [2:0]       mode_q;
  logic [W-1:0]     data_q;
  logic             valid_q;
  logic             fix_q;
  logic             inj_q;
  logic [CNT_W-1:0] cnt_q;

  logic             gen;
  logic             load;
  logic             xfer;
  logic             inj_pend;
  logic             load_ok;
  logic             seed_lock;
  logic [30:0]      load_mask;
  logic [30:0]      seed_m;
  logic [30:0]      step_nxt;
  logic [W-1:0]     step_word;

  prbs_lfsr_step #(.W(W)) u_step (
    .state     (lfsr_q),
    .mode      (mode_q),
    .state_nxt (step_nxt),
    .word      (step_word)
  );

  assign xfer      = valid_q & bus.i_ready;
  assign inj_pend  = inj_q | bus.i_inj;
  assign load_mask = mode_mask(bus.i_mode);
  assign seed_m    = bus.i_seed & load_mask;
  assign seed_lock = (seed_m == load_mask);
  assign load_ok   = load & mode_legal(bus.i_mode);

  // Next-state decode; a load strobe in IDLE takes priority over i_en.
  always_comb begin
    state_d = state_q;
    gen     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_load) begin
          load = 1'b1;
        end else if (bus.i_en) begin
          gen     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (bus.i_en) gen = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output word register; valid follows the registered FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= (state_d == ST_RUN);
      if (gen) data_q <= step_word ^ W'(inj_pend);
    end
  end

  // LFSR state, mode and lockup-seed replacement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED & mode_mask(DEFAULT_MODE);
      mode_q <= DEFAULT_MODE;
      fix_q  <= 1'b0;
    end else if (load_ok) begin
      mode_q <= bus.i_mode;
      lfsr_q <= seed_lock ? 31'd0 : seed_m;
      fix_q  <= fix_q | seed_lock;
    end else if (gen) begin
      lfsr_q <= step_nxt;
    end
  end

  // Inject flag: armed by any pulse, consumed by the next generated word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      inj_q <= 1'b0;
    else if (gen) inj_q <= 1'b0;
    else          inj_q <= inj_pend;
  end

  // Transferred-word counter, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_seed_fix = fix_q;
  assign bus.o_cnt      = cnt_q;

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen: a W=9 PRBS9 instance and a W=1 PRBS7 instance.
module tb_prbs_gen;

  logic clk;
  logic rst9;
  logic rst1;

  int n_checks;
  int n_fail;

  logic mb  [254];
  logic cap [254];

  prbs_if #(.W(9), .CNT_W(32)) bus9 ();
  prbs_if #(.W(1), .CNT_W(32)) bus1 ();

  prbs_gen #(.W(9), .DEFAULT_MODE(3'd1), .SEED(31'd0), .CNT_W(32)) dut9 (
    .clk (clk),
    .rst (rst9),
    .bus (bus9)
  );

  prbs_gen #(.W(1), .DEFAULT_MODE(3'd0), .SEED(31'd0), .CNT_W(32)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #3;
    n_checks++;
    if (bus9.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid9: got %0b expected 0", bus9.o_valid); end
    n_checks++;
    if (bus9.o_data !== 9'h000) begin n_fail++; $display("FAIL reset_data9: got %0h expected 0", bus9.o_data); end
    n_checks++;
    if (bus9.o_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt9: got %0d expected 0", bus9.o_cnt); end
    n_checks++;
    if (bus9.o_seed_fix !== 1'b0) begin n_fail++; $display("FAIL reset_fix9: got %0b expected 0", bus9.o_seed_fix); end
    n_checks++;
    if (bus1.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %0b expected 0", bus1.o_valid); end
    @(negedge clk);
    rst9 = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic test_basic_w9();
    logic [8:0] exp9 [3];
    exp9[0] = 9'h000;
    exp9[1] = 9'h01F;
    exp9[2] = 9'h1C1;
    @(posedge clk); #1;
    bus9.i_en    = 1'b1;
    bus9.i_ready = 1'b1;
    #1;
    n_checks++;
    if (bus9.o_valid !== 1'b0) begin n_fail++; $display("FAIL valid_before_edge: got %0b expected 0", bus9.o_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus9.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %0b expected 1", i, bus9.o_valid); end
      n_checks++;
      if (bus9.o_data !== exp9[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %03h expected %03h", i, bus9.o_data, exp9[i]); end
      if (i == 2) bus9.i_en = 1'b0;
    end
    @(posedge clk); #1;
    bus9.i_ready = 1'b0;
    n_checks++;
    if (bus9.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %0b expected 0", bus9.o_valid); end
    n_checks++;
    if (bus9.o_cnt !== 32'd3) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 3", bus9.o_cnt); end
  endtask

  task automatic test_prbs7_period();
    for (int n = 0; n < 254; n++) begin
      if (n < 7) mb[n] = 1'b0;
      else       mb[n] = ~(mb[n-7] ^ mb[n-6]);
    end
    @(posedge clk); #1;
    bus1.i_en    = 1'b1;
    bus1.i_ready = 1'b1;
    for (int i = 0; i < 254; i++) begin
      @(posedge clk); #1;
      cap[i] = bus1.o_data[0];
      n_checks++;
      if (bus1.o_valid !== 1'b1) begin n_fail++; $display("FAIL p7_valid[%0d]: got %0b expected 1", i, bus1.o_valid); end
      if (i == 200) begin
        n_checks++;
        if (bus1.o_cnt !== 32'd200) begin n_fail++; $display("FAIL p7_cnt_mid: got %0d expected 200", bus1.o_cnt); end
      end
      if (i == 253) bus1.i_en = 1'b0;
    end
    @(posedge clk); #1;
    bus1.i_ready = 1'b0;
    n_checks++;
    if (bus1.o_valid !== 1'b0) begin n_fail++; $display("FAIL p7_idle_valid: got %0b expected 0", bus1.o_valid); end
    n_checks++;
    if (bus1.o_cnt !== 32'd254) begin n_fail++; $display("FAIL p7_cnt: got %0d expected 254", bus1.o_cnt); end
    for (int i = 0; i < 254; i++) begin
      n_checks++;
      if (cap[i] !== mb[i]) begin n_fail++; $display("FAIL p7_bit[%0d]: got %0b expected %0b", i, cap[i], mb[i]); end
    end
  endtask

  task automatic test_seed_fix();
    @(posedge clk); #1;
    bus1.i_load = 1'b1;
    bus1.i_mode = 3'd0;
    bus1.i_seed = 31'h7F;
    @(posedge clk); #1;
    bus1.i_load = 1'b0;
    n_checks++;
    if (bus1.o_seed_fix !== 1'b1) begin n_fail++; $display("FAIL seed_fix_flag: got %0b expected 1", bus1.o_seed_fix); end
    bus1.i_en    = 1'b1;
    bus1.i_ready = 1'b1;
    for (int i = 0; i < 127; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus1.o_data[0] !== mb[i]) begin n_fail++; $display("FAIL seed_fix_bit[%0d]: got %0b expected %0b", i, bus1.o_data[0], mb[i]); end
      if (i == 126) bus1.i_en = 1'b0;
    end
    @(posedge clk); #1;
    bus1.i_ready = 1'b0;
    n_checks++;
    if (bus1.o_valid !== 1'b0) begin n_fail++; $display("FAIL seed_fix_idle: got %0b expected 0", bus1.o_valid); end
  endtask

  task automatic test_inject();
    @(posedge clk); #1;
    bus9.i_load = 1'b1;
    bus9.i_mode = 3'd1;
    bus9.i_seed = 31'd0;
    @(posedge clk); #1;
    bus9.i_load  = 1'b0;
    bus9.i_en    = 1'b1;
    bus9.i_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus9.o_data !== 9'h000) begin n_fail++; $display("FAIL inj_word0: got %03h expected 000", bus9.o_data); end
    bus9.i_inj = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus9.i_inj = 1'b0;
    n_checks++;
    if (bus9.o_data !== 9'h000) begin n_fail++; $display("FAIL inj_held_word: got %03h expected 000", bus9.o_data); end
    bus9.i_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus9.o_data !== 9'h01E) begin n_fail++; $display("FAIL inj_word1: got %03h expected 01e", bus9.o_data); end
    @(posedge clk); #1;
    bus9.i_ready = 1'b0;
    n_checks++;
    if (bus9.o_data !== 9'h1C1) begin n_fail++; $display("FAIL inj_word2: got %03h expected 1c1", bus9.o_data); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus9.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b expected 1", i, bus9.o_valid); end
      n_checks++;
      if (bus9.o_data !== 9'h1C1) begin n_fail++; $display("FAIL bp_data[%0d]: got %03h expected 1c1", i, bus9.o_data); end
      if (i == 2) bus9.i_en = 1'b0;
    end
    n_checks++;
    if (bus9.o_cnt !== 32'd5) begin n_fail++; $display("FAIL bp_cnt_stall: got %0d expected 5", bus9.o_cnt); end
    bus9.i_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus9.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid: got %0b expected 0", bus9.o_valid); end
    n_checks++;
    if (bus9.o_cnt !== 32'd6) begin n_fail++; $display("FAIL bp_cnt_after: got %0d expected 6", bus9.o_cnt); end
    @(posedge clk); #1;
    bus9.i_ready = 1'b0;
    n_checks++;
    if (bus9.o_cnt !== 32'd6) begin n_fail++; $display("FAIL bp_cnt_once: got %0d expected 6", bus9.o_cnt); end
  endtask

  task automatic test_async_reset();
    logic [8:0] exp9 [3];
    exp9[0] = 9'h000;
    exp9[1] = 9'h01F;
    exp9[2] = 9'h1C1;
    bus9.i_en    = 1'b1;
    bus9.i_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus9.o_valid !== 1'b1) begin n_fail++; $display("FAIL ar_running: got %0b expected 1", bus9.o_valid); end
    #2;
    rst9 = 1'b1;
    #1;
    n_checks++;
    if (bus9.o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_async: got %0b expected 0", bus9.o_valid); end
    n_checks++;
    if (bus9.o_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d expected 0", bus9.o_cnt); end
    bus9.i_en    = 1'b0;
    bus9.i_ready = 1'b0;
    @(negedge clk);
    rst9 = 1'b0;
    @(posedge clk); #1;
    bus9.i_load = 1'b1;
    bus9.i_mode = 3'd6;
    bus9.i_seed = 31'h55;
    @(posedge clk); #1;
    bus9.i_load  = 1'b0;
    bus9.i_en    = 1'b1;
    bus9.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus9.o_data !== exp9[i]) begin n_fail++; $display("FAIL ar_word[%0d]: got %03h expected %03h", i, bus9.o_data, exp9[i]); end
      if (i == 2) bus9.i_en = 1'b0;
    end
    @(posedge clk); #1;
    bus9.i_ready = 1'b0;
    n_checks++;
    if (bus9.o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got %0b expected 0", bus9.o_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst9 = 1'b1;
    rst1 = 1'b1;
    bus9.i_en = 1'b0; bus9.i_load = 1'b0; bus9.i_mode = 3'd0; bus9.i_seed = 31'd0;
    bus9.i_inj = 1'b0; bus9.i_ready = 1'b0;
    bus1.i_en = 1'b0; bus1.i_load = 1'b0; bus1.i_mode = 3'd0; bus1.i_seed = 31'd0;
    bus1.i_inj = 1'b0; bus1.i_ready = 1'b0;

    test_reset();
    test_basic_w9();
    test_prbs7_period();
    test_seed_fix();
    test_inject();
    test_backpressure();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_gen.md
# prbs_gen

Parametrised multi-polynomial PRBS source for the QPSK transmit path. It produces W sequence bits per clock over a valid/ready stream. Polynomial and seed are runtime-selectable, and it supports single-bit error injection for BER-checker tests. It replaces the fixed single-bit PRBS9 generator ahead of the symbol mapper.

## Interface
- W, 1: bits per output word, legal 1..32.
- DEFAULT_MODE, 1: mode after reset (encoding below).
- SEED, 0: state after reset; bits above the active length are ignored.
- CNT_W, 32: width of the transferred-word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_en  in  1  run request
- i_load  in  1  load i_mode/i_seed (single-cycle strobe)
- i_mode  in  3  0=PRBS7 x^7+x^6+1, 1=PRBS9 x^9+x^5+1, 2=PRBS15 x^15+x^14+1, 3=PRBS23 x^23+x^18+1, 4=PRBS31 x^31+x^28+1, 5..7 reserved
- i_seed  in  31  seed; only bits [L-1:0] used
- i_inj  in  1  invert bit 0 of the next word generated
- i_ready  in  1  downstream accept
- o_data  out  W  word; bit 0 is the earliest sequence bit
- o_valid  out  1  o_data valid
- o_seed_fix  out  1  sticky: a lockup seed was replaced
- o_cnt  out  CNT_W  words transferred, wraps

## Operation
- Sequence definition, per mode with length L and tap k: b[n+L] = ~(b[n] ^ b[n+L-k]) (XNOR form).
  - State s[i] = b[n+i]. A single step shifts right and inserts the feedback at s[L-1].
  - All-ones in [L-1:0] is the lockup state. All-zeros is legal.
- Each word takes the next W sequence bits. State advances by W steps per generated word.
- FSM states:
  - IDLE: o_valid=0. i_load is honoured here only.
    - Reserved i_mode: the whole load is ignored.
    - Seed all-ones in [L-1:0]: state is loaded with 0 and o_seed_fix is set.
    - i_load has priority over i_en in the same cycle.
    - i_en=1 and no i_load: generate the first word, go to RUN.
  - RUN: o_valid=1, o_data held stable until i_ready.
    - On a transfer with i_en=1: generate the next word, stay in RUN.
    - On a transfer with i_en=0: go to IDLE, o_valid=0.
    - i_en falling without a transfer: the current word stays valid until accepted. No word is ever withdrawn.
    - i_load in RUN is ignored.
- Error injection:
  - An i_inj pulse arms a flag.
  - The next generated word has bit 0 inverted, then the flag clears.
  - The LFSR state is never affected.
  - Multiple pulses before one word still produce a single inversion.
- o_cnt increments on every o_valid & i_ready and wraps to 0.
- o_seed_fix clears only on rst.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - state = SEED masked to the DEFAULT_MODE length; mode = DEFAULT_MODE
  - FSM = IDLE; o_valid = 0, o_data = 0, o_cnt = 0, o_seed_fix = 0, inject flag = 0
- i_en sampled high in IDLE at edge t gives o_valid=1 after edge t, holding b[0..W-1].
- Back-to-back throughput with i_ready held high: one word per cycle, no bubbles.
- A load at edge t takes effect for the word generated at edge t+1 or later. i_en must be high at that edge.
- rst mid-word: o_valid drops immediately (asynchronous) and the pending word is lost.
- All outputs are registered. No combinational path from i_ready to o_valid.

## Structure
- Shared package prbs_pkg holds:
  - mode encodings
  - per-mode L and k constants
  - an active-bit mask function
  - the FSM state encoding
- Sub-module prbs_lfsr_step: combinational. Inputs are state[30:0], mode and W. Outputs are the next state after W steps and the W-bit word. It is built as an unrolled loop of single steps.
- Top: FSM, output register, inject flag, counter, load/lockup logic.

## Test plan
- Reset with defaults, then i_en=1, i_ready=1, W=9:
  - o_valid rises one cycle after i_en.
  - Words are 0x000, 0x01F, 0x1C1.
- W=1, PRBS7, seed 0, ready=1:
  - Words 127..253 equal words 0..126.
  - o_cnt = 254 after 254 transfers.
- Load PRBS7 with seed 0x7F:
  - o_seed_fix = 1.
  - The output sequence is identical to the seed-0 run.
- W=9, pulse i_inj during the first word:
  - The second word is 0x01E.
  - The third word is 0x1C1 (no propagation).
- Backpressure:
  - i_ready=0 for 5 cycles: o_data and o_valid remain stable.
  - Drop i_en during the stall: the word is transferred once when i_ready rises, then IDLE.
- Assert rst asynchronously mid-run:
  - o_valid = 0 before the next edge.
  - After release, the sequence restarts at 0x000.
  - A load with i_mode=6 leaves the mode as PRBS9.
